// File: rtl/ula_display_pkg.sv
// ula_display_pkg: FSM states, segment constants and BCD adjust helper for ula_display_ctrl
package ula_display_pkg;
  typedef enum logic [1:0] {IDLE, CONV, WRITE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/ula_display_if.sv
// ula_display_if: ALU-to-display bus (Load, In in; Ready, Done, OutA/OutB/OutC/OutS out); slave=controller, master=ALU
interface ula_display_if;
  logic       Load;
  logic [7:0] In;
  logic       Ready;
  logic       Done;
  logic [6:0] OutA;
  logic [6:0] OutB;
  logic [6:0] OutC;
  logic [6:0] OutS;
  modport master (output Load, In, input Ready, Done, OutA, OutB, OutC, OutS);
  modport slave (input Load, In, output Ready, Done, OutA, OutB, OutC, OutS);
endinterface

// File: rtl/seg7_digit.sv
// seg7_digit: combinational BCD nibble (bcd_i) to active-low gfedcba pattern (seg_o), blank above 9
module seg7_digit
  import ula_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);
  assign seg_o = bcd_i > 4'd9 ? SEG_BLANK : SEG_DIGIT[bcd_i];
endmodule

// File: rtl/ula_display_ctrl.sv
// ula_display_ctrl: signed 8-bit capture, iterative shift-add-3 BCD, registered 7-seg outputs (Clock, Reset, bus slave; option DISPLAY_LZ_BLANK_EN)
module ula_display_ctrl
  import ula_display_pkg::*;
(
  input logic         Clock,
  input logic         Reset,
  ula_display_if.slave bus
);
  state_t      state_q, state_d;
  logic        neg_q, neg_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] bcd_q, bcd_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  a_q, a_d, b_q, b_d, c_q, c_d, s_q, s_d;
  logic        done_q, done_d;
  logic [11:0] adj;
  logic [6:0]  seg_a, seg_b, seg_c, lz_b, lz_c;
  assign adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  seg7_digit u_a (.bcd_i(bcd_q[3:0]),  .seg_o(seg_a));
  seg7_digit u_b (.bcd_i(bcd_q[7:4]),  .seg_o(seg_b));
  seg7_digit u_c (.bcd_i(bcd_q[11:8]), .seg_o(seg_c));
`ifdef DISPLAY_LZ_BLANK_EN
  assign lz_c = bcd_q[11:8] == 4'd0 ? SEG_BLANK : seg_c;
  assign lz_b = bcd_q[11:4] == 8'd0 ? SEG_BLANK : seg_b;
`else
  assign lz_c = seg_c;
  assign lz_b = seg_b;
`endif
  always_comb begin
    state_d = state_q;
    neg_d = neg_q;
    mag_d = mag_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    s_d = s_q;
    done_d = state_q == WRITE;
    if (state_q == IDLE && bus.Load) begin
      state_d = CONV;
      neg_d = bus.In[7];
      mag_d = bus.In[7] ? -bus.In : bus.In;
      bcd_d = '0;
      cnt_d = '0;
    end
    if (state_q == CONV) begin
      {bcd_d, mag_d} = {adj, mag_q} << 1;
      cnt_d = cnt_q + 3'd1;
      state_d = cnt_q == 3'd7 ? WRITE : CONV;
    end
    if (state_q == WRITE) begin
      state_d = IDLE;
      a_d = seg_a;
      b_d = lz_b;
      c_d = lz_c;
      s_d = neg_q ? SEG_MINUS : SEG_BLANK;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      neg_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      a_q <= SEG_BLANK;
      b_q <= SEG_BLANK;
      c_q <= SEG_BLANK;
      s_q <= SEG_BLANK;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q <= neg_d;
      mag_q <= mag_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      s_q <= s_d;
      done_q <= done_d;
    end
  end
  assign bus.Ready = state_q == IDLE;
  assign bus.Done = done_q;
  assign bus.OutA = a_q;
  assign bus.OutB = b_q;
  assign bus.OutC = c_q;
  assign bus.OutS = s_q;
endmodule
